siganfu_fire_arbiter: RTL and testbench
=======================================

Name: siganfu_fire_arbiter

Overview:
Shares one siganfu machine gun between NREQ gunner consoles. Each console presents its own fire request and target qualifiers. The block grants the gun to one console at a time using round-robin order and a fairness quantum. It drives the gun's fire_command, target_locked, is_enemy and firing_mode inputs, and watches the gun's current_state so it can freeze on downfall.

Parameters:
NREQ, 4, number of gunner consoles (2..8)
QUANTUM, 16, maximum OWN cycles for one owner while another console is requesting
GAP, 2, dead cycles with all gun inputs low between two owners

Ports:
sysclk  input  1  system clock, rising edge
reboot_n  input  1  asynchronous active-low reset
req  input  NREQ  per-console fire request (level)
lock_in  input  NREQ  per-console target_locked
enemy_in  input  NREQ  per-console is_enemy
mode_in  input  NREQ  per-console firing mode (0 single, 1 auto)
gun_state  input  3  gun current_state: 0 idle, 1 single, 2 auto, 3 reload, 4 overheat, 5 downfall
grant  output  NREQ  one-hot current owner, all-zero when no owner
fire_command  output  1  to gun
target_locked  output  1  to gun
is_enemy  output  1  to gun
firing_mode  output  1  to gun
halted  output  1  gun in downfall; arbiter frozen

Behaviour:
- One clock (sysclk); reset is asynchronous, active-low (reboot_n). All outputs are registered.
- Reset values: grant=0, fire_command=0, target_locked=0, is_enemy=0, firing_mode=0, halted=0; state=IDLE; quantum counter=0; gap counter=0; rotation pointer=NREQ-1, so console 0 wins first.
- Reset asserted mid-operation: all of the above take effect immediately, regardless of state.
- FSM states: IDLE, OWN, GAP, HALT.
- IDLE:
  - If any req bit is high, pick the first requester strictly after the pointer, wrapping NREQ-1 -> 0.
  - At that edge: go to OWN, set grant one-hot, latch mode_in[owner] into firing_mode, clear the quantum counter.
  - Latency: req sampled high at edge k -> grant valid after edge k. fire_command follows from edge k+1.
  - If no req bit is high, stay in IDLE with all outputs 0.
- OWN:
  - Each edge: fire_command <= req[owner], target_locked <= lock_in[owner], is_enemy <= enemy_in[owner].
  - firing_mode holds its latched value; mode_in changes during ownership are ignored.
  - Quantum counter increments each OWN cycle in which any other console requests.
  - The quantum counter holds while gun_state is 3 or 4, so reload and overheat do not charge the owner.
  - The quantum counter saturates at QUANTUM.
- Leaving OWN:
  - Voluntary release: req[owner]=0.
  - Preemption: quantum counter = QUANTUM while another console requests.
  - On either, at the next edge go to GAP: grant=0, all gun inputs 0, pointer <= owner index.
  - Release and quantum expiry in the same cycle cause a single transition to GAP.
- GAP:
  - Hold all outputs 0 for exactly GAP cycles (gap counter), then go to IDLE.
  - Requests arriving during GAP are served by the next IDLE arbitration.
- HALT:
  - gun_state==5 sampled in any state -> next edge goes to HALT. This has priority over every other transition.
  - In HALT: grant=0, all gun inputs 0, halted=1.
  - Only reboot_n exits HALT; gun_state returning to non-5 is ignored.
- Widths: quantum counter is clog2(QUANTUM+1) bits; gap counter is clog2(GAP+1) bits; pointer is clog2(NREQ) bits. No counter wraps; each saturates or clears.
- grant is always one-hot or zero, and fire_command is never high while grant is zero.

Test Plan:
- Reset, then req=4'b0001, lock/enemy=1, mode_in[0]=1 -> grant=0001 one edge later; next edge fire_command=1, firing_mode=1, target_locked=1, is_enemy=1.
- req=4'b0110 from IDLE after reset -> grant=0010. Console 1 drops req -> 2 dead cycles with all outputs 0 -> grant=0100.
- Console 0 holds req, console 3 raises req at OWN start -> after 16 OWN cycles grant drops, GAP=2 cycles, grant=1000. Console 0 is re-served only after console 3 releases.
- Repeat the previous case with gun_state=4 for 10 of the OWN cycles -> preemption delayed to 26 OWN cycles.
- Toggle mode_in[owner] 1->0 during OWN -> firing_mode stays 1 until release.
- gun_state=5 during OWN while another req is pending -> next edge halted=1, all outputs 0. Stays halted after gun_state=0. reboot_n low -> reset values; console 0 wins next.

Source files
------------

// File: rtl/siganfu_fire_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | siganfu_fire_arbiter_if : console-side / gun-side bundle of arbiter   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface siganfu_fire_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] lock_in;
    logic [NREQ-1:0] enemy_in;
    logic [NREQ-1:0] mode_in;
    logic [2:0]      gun_state;
    logic [NREQ-1:0] grant;
    logic            fire_command;
    logic            target_locked;
    logic            is_enemy;
    logic            firing_mode;
    logic            halted;

    modport master (
        output req, lock_in, enemy_in, mode_in, gun_state,
        input  grant, fire_command, target_locked, is_enemy, firing_mode, halted
    );

    modport slave (
        input  req, lock_in, enemy_in, mode_in, gun_state,
        output grant, fire_command, target_locked, is_enemy, firing_mode, halted
    );
endinterface
`default_nettype wire

// File: rtl/siganfu_fire_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | siganfu_fire_arbiter : round-robin, quantum-limited gun sharing       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module siganfu_fire_arbiter #(
    parameter int NREQ    = 4,
    parameter int QUANTUM = 16,
    parameter int GAP     = 2
) (
    input  logic                    sysclk,
    input  logic                    reboot_n,
    siganfu_fire_arbiter_if.slave   bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int QW = $clog2(QUANTUM + 1);
    localparam int GW = $clog2(GAP + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN  = 2'd1;
    localparam logic [1:0] GAPS = 2'd2;
    localparam logic [1:0] HALT = 2'd3;

    logic [1:0]      state_q,  state_d;
    logic [NREQ-1:0] grant_q,  grant_d;
    logic [PW-1:0]   owner_q,  owner_d;
    logic [PW-1:0]   ptr_q,    ptr_d;
    logic [QW-1:0]   qcnt_q,   qcnt_d;
    logic [GW-1:0]   gcnt_q,   gcnt_d;
    logic            fire_q,   fire_d;
    logic            lock_q,   lock_d;
    logic            enemy_q,  enemy_d;
    logic            mode_q,   mode_d;
    logic            halted_q, halted_d;

    logic            pick_valid;
    logic [PW-1:0]   pick_idx;
    logic            others_req;
    logic            start_own;
    int              idx;

    // Scan from farthest to nearest so the first requester after ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (bus.req[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = idx[PW-1:0];
            end
        end
    end

    assign others_req = |(bus.req & ~grant_q);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        qcnt_d    = qcnt_q;
        gcnt_d    = gcnt_q;
        fire_d    = 1'b0;
        lock_d    = 1'b0;
        enemy_d   = 1'b0;
        mode_d    = mode_q;
        halted_d  = halted_q;
        start_own = 1'b0;

        case (state_q)
            IDLE: begin
                start_own = pick_valid;
            end
            OWN: begin
                if (!bus.req[owner_q] ||
                    (qcnt_q == QW'(QUANTUM) && others_req)) begin
                    state_d = GAPS;
                    grant_d = '0;
                    mode_d  = 1'b0;
                    ptr_d   = owner_q;
                    gcnt_d  = '0;
                end else begin
                    fire_d  = bus.req[owner_q];
                    lock_d  = bus.lock_in[owner_q];
                    enemy_d = bus.enemy_in[owner_q];
                    if (others_req && bus.gun_state != 3'd3 &&
                        bus.gun_state != 3'd4 && qcnt_q != QW'(QUANTUM))
                        qcnt_d = qcnt_q + 1'b1;
                end
            end
            GAPS: begin
                // The final dead cycle arbitrates so the next owner appears
                // exactly GAP cycles after the previous one let go.
                if (gcnt_q == GW'(GAP - 1)) begin
                    gcnt_d = '0;
                    if (pick_valid) start_own = 1'b1;
                    else            state_d   = IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_own) begin
            state_d = OWN;
            grant_d = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
            owner_d = pick_idx;
            mode_d  = bus.mode_in[pick_idx];
            qcnt_d  = '0;
        end

        if (bus.gun_state == 3'd5) begin
            state_d  = HALT;
            grant_d  = '0;
            fire_d   = 1'b0;
            lock_d   = 1'b0;
            enemy_d  = 1'b0;
            mode_d   = 1'b0;
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge reboot_n) begin
        if (!reboot_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            ptr_q    <= PW'(NREQ - 1);
            qcnt_q   <= '0;
            gcnt_q   <= '0;
            fire_q   <= 1'b0;
            lock_q   <= 1'b0;
            enemy_q  <= 1'b0;
            mode_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            qcnt_q   <= qcnt_d;
            gcnt_q   <= gcnt_d;
            fire_q   <= fire_d;
            lock_q   <= lock_d;
            enemy_q  <= enemy_d;
            mode_q   <= mode_d;
            halted_q <= halted_d;
        end
    end

    assign bus.grant         = grant_q;
    assign bus.fire_command  = fire_q;
    assign bus.target_locked = lock_q;
    assign bus.is_enemy      = enemy_q;
    assign bus.firing_mode   = mode_q;
    assign bus.halted        = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_siganfu_fire_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_siganfu_fire_arbiter : directed self-checking bench                |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_siganfu_fire_arbiter;
    logic sysclk;
    logic reboot_n;
    int   n_checks;
    int   n_errors;

    siganfu_fire_arbiter_if #(.NREQ(4)) bus ();

    siganfu_fire_arbiter #(.NREQ(4), .QUANTUM(16), .GAP(2)) dut (
        .sysclk   (sysclk),
        .reboot_n (reboot_n),
        .bus      (bus)
    );

    // {halted, firing_mode, is_enemy, target_locked, fire_command, grant[3:0]}
    logic [8:0] outs;
    assign outs = {bus.halted, bus.firing_mode, bus.is_enemy, bus.target_locked,
                   bus.fire_command, bus.grant};

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic do_reset();
        reboot_n      = 1'b0;
        bus.req       = '0;
        bus.lock_in   = '0;
        bus.enemy_in  = '0;
        bus.mode_in   = '0;
        bus.gun_state = 3'd0;
        tick();
        tick();
        reboot_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Reset state
        do_reset();
        check("reset_outs", 32'(outs), 32'h000);
        tick();
        check("idle_no_req", 32'(outs), 32'h000);

        // Single requester, latency and qualifier forwarding
        bus.req = 4'b0001; bus.lock_in = 4'b0001;
        bus.enemy_in = 4'b0001; bus.mode_in = 4'b0001;
        tick();
        check("t1_grant_edge", 32'(outs), 32'h081);
        tick();
        check("t1_fire_edge", 32'(outs), 32'h0F1);
        bus.req = 4'b0000;
        tick();
        check("t1_release", 32'(outs), 32'h000);

        // Round robin from reset pointer and GAP dead time
        do_reset();
        bus.req = 4'b0110;
        tick();
        check("t2_grant1", 32'(bus.grant), 32'h2);
        tick();
        check("t2_fire1", 32'(outs), 32'h012);
        bus.req = 4'b0100;
        tick();
        check("t2_dead1", 32'(outs), 32'h000);
        tick();
        check("t2_dead2", 32'(outs), 32'h000);
        tick();
        check("t2_grant2", 32'(bus.grant), 32'h4);

        // Quantum preemption
        do_reset();
        bus.req = 4'b0001;
        tick();
        check("t3_grant0", 32'(bus.grant), 32'h1);
        bus.req = 4'b1001;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("t3_hold%0d", i), 32'(bus.grant), 32'h1);
        end
        tick();
        check("t3_preempt", 32'(outs), 32'h000);
        tick();
        check("t3_gap2", 32'(outs), 32'h000);
        tick();
        check("t3_grant3", 32'(bus.grant), 32'h8);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_owner3_keeps", 32'(bus.grant), 32'h8);
        end
        bus.req = 4'b0001;
        tick();
        check("t3_rel3", 32'(bus.grant), 32'h0);
        tick();
        tick();
        check("t3_regrant0", 32'(bus.grant), 32'h1);

        // Overheat does not charge the quantum
        do_reset();
        bus.req = 4'b0001;
        tick();
        bus.req = 4'b1001;
        bus.gun_state = 3'd4;
        for (int i = 1; i <= 26; i++) begin
            if (i == 11) bus.gun_state = 3'd0;
            tick();
            check($sformatf("t4_hold%0d", i), 32'(bus.grant), 32'h1);
        end
        tick();
        check("t4_preempt", 32'(bus.grant), 32'h0);
        tick();
        tick();
        check("t4_grant3", 32'(bus.grant), 32'h8);

        // firing_mode latched at grant
        do_reset();
        bus.req = 4'b0001; bus.mode_in = 4'b0001;
        tick();
        bus.mode_in = 4'b0000;
        tick();
        check("t5_mode_a", 32'(bus.firing_mode), 32'h1);
        tick();
        check("t5_mode_b", 32'(bus.firing_mode), 32'h1);
        bus.req = 4'b0000;
        tick();
        check("t5_mode_rel", 32'(bus.firing_mode), 32'h0);

        // Downfall freeze, only reset exits
        do_reset();
        bus.req = 4'b0011;
        tick();
        tick();
        check("t6_pre_halt", 32'(outs), 32'h011);
        bus.gun_state = 3'd5;
        tick();
        check("t6_halt", 32'(outs), 32'h100);
        bus.gun_state = 3'd0;
        tick();
        tick();
        check("t6_stay_halt", 32'(outs), 32'h100);
        reboot_n = 1'b0;
        #1;
        check("t6_async_reset", 32'(outs), 32'h000);
        tick();
        reboot_n = 1'b1;
        tick();
        check("t6_after_reset", 32'(bus.grant), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
